// File: rtl/collision_pkg.sv
// Shared definitions for the collision scan unit.
//   state_t         : scan FSM encoding (IDLE / SCAN / REPORT)
//   DEF_*           : default parameter values
//   clog2           : ceiling log2 for parameter arithmetic
//   seg_idx_width   : segment index width, never less than 1 bit
package collision_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam int DEF_NUM_SEGMENTS = 7;
    localparam int DEF_NUM_ENTITIES = 3;
    localparam int DEF_POS_WIDTH    = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int seg_idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/position_comparator.sv
// Equality check of two packed {row, col} positions, gated by an enable.
//   a, b    : positions to compare
//   enable  : comparison only counts when high
//   match   : enable & (a == b), combinational
module position_comparator #(
    parameter int POS_WIDTH = 8
) (
    input  logic [POS_WIDTH-1:0] a,
    input  logic [POS_WIDTH-1:0] b,
    input  logic                 enable,
    output logic                 match
);

    assign match = enable & (a == b);

endmodule

// File: rtl/collision_scan_unit.sv
// Frame-based collision detector: snapshots entity and dragon-segment
// positions on frame_start, scans one segment per cycle against all
// entities in parallel, then publishes registered results with a done pulse.
//   clk, reset      : clock, async active-high reset
//   frame_start     : one-cycle scan request
//   entity_pos/valid: entity positions and participation mask
//   segment_pos/active: segment positions and participation mask
//   busy            : scan in progress
//   done            : one-cycle pulse when results update
//   collision       : per-entity hit flags
//   hit_segment     : per-entity lowest hit segment index (0 if none)
//   any_collision   : OR of collision
//   overrun         : one-cycle pulse when a request arrived mid-scan
//
// state  | meaning
// IDLE   | waiting for frame_start
// SCAN   | comparing snapshot segment[seg_idx] against all entities
// REPORT | accumulators final; results publish at the next edge
module collision_scan_unit
    import collision_pkg::*;
#(
    parameter int  NUM_SEGMENTS = DEF_NUM_SEGMENTS,
    parameter int  NUM_ENTITIES = DEF_NUM_ENTITIES,
    parameter int  POS_WIDTH    = DEF_POS_WIDTH,
    localparam int SEG_IDX_W    = seg_idx_width(NUM_SEGMENTS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              frame_start,
    input  logic [NUM_ENTITIES*POS_WIDTH-1:0] entity_pos,
    input  logic [NUM_ENTITIES-1:0]           entity_valid,
    input  logic [NUM_SEGMENTS*POS_WIDTH-1:0] segment_pos,
    input  logic [NUM_SEGMENTS-1:0]           segment_active,
    output logic                              busy,
    output logic                              done,
    output logic [NUM_ENTITIES-1:0]           collision,
    output logic [NUM_ENTITIES*SEG_IDX_W-1:0] hit_segment,
    output logic                              any_collision,
    output logic                              overrun
);

    localparam logic [SEG_IDX_W-1:0] LAST_SEG = SEG_IDX_W'(NUM_SEGMENTS - 1);

    state_t                            state, state_next;
    logic                              capture;
    logic [SEG_IDX_W-1:0]              seg_idx;
    logic [POS_WIDTH-1:0]              snap_entity [NUM_ENTITIES];
    logic [NUM_ENTITIES-1:0]           snap_valid;
    logic [POS_WIDTH-1:0]              snap_segment [NUM_SEGMENTS];
    logic [NUM_SEGMENTS-1:0]           snap_active;
    logic [NUM_ENTITIES-1:0]           acc_hit;
    logic [NUM_ENTITIES*SEG_IDX_W-1:0] acc_idx;
    logic [POS_WIDTH-1:0]              cur_segment;
    logic                              cur_active;
    logic [NUM_ENTITIES-1:0]           match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    capture    = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (seg_idx == LAST_SEG) begin
                    state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                // A request in the report cycle starts the next scan directly.
                if (frame_start) begin
                    capture    = 1'b1;
                    state_next = ST_SCAN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_valid  <= '0;
            snap_active <= '0;
            for (int e = 0; e < NUM_ENTITIES; e++) begin
                snap_entity[e] <= '0;
            end
            for (int s = 0; s < NUM_SEGMENTS; s++) begin
                snap_segment[s] <= '0;
            end
        end else if (capture) begin
            snap_valid  <= entity_valid;
            snap_active <= segment_active;
            for (int e = 0; e < NUM_ENTITIES; e++) begin
                snap_entity[e] <= entity_pos[e*POS_WIDTH +: POS_WIDTH];
            end
            for (int s = 0; s < NUM_SEGMENTS; s++) begin
                snap_segment[s] <= segment_pos[s*POS_WIDTH +: POS_WIDTH];
            end
        end
    end

    assign cur_segment = snap_segment[seg_idx];
    assign cur_active  = snap_active[seg_idx];

    for (genvar e = 0; e < NUM_ENTITIES; e++) begin : g_cmp
        position_comparator #(
            .POS_WIDTH (POS_WIDTH)
        ) u_cmp (
            .a      (snap_entity[e]),
            .b      (cur_segment),
            .enable (snap_valid[e] & cur_active),
            .match  (match[e])
        );
    end

    // Only the first hit per entity records its index, so acc_idx holds
    // the lowest hit segment; entities with no hit keep the cleared 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_idx <= '0;
            acc_hit <= '0;
            acc_idx <= '0;
        end else if (capture) begin
            seg_idx <= '0;
            acc_hit <= '0;
            acc_idx <= '0;
        end else if (state == ST_SCAN) begin
            for (int e = 0; e < NUM_ENTITIES; e++) begin
                if (match[e] && !acc_hit[e]) begin
                    acc_hit[e]                          <= 1'b1;
                    acc_idx[e*SEG_IDX_W +: SEG_IDX_W] <= seg_idx;
                end
            end
            if (seg_idx != LAST_SEG) begin
                seg_idx <= seg_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun       <= 1'b0;
            collision     <= '0;
            hit_segment   <= '0;
            any_collision <= 1'b0;
        end else begin
            busy    <= (state_next != ST_IDLE);
            done    <= (state == ST_REPORT);
            overrun <= (state == ST_SCAN) && frame_start;
            if (state == ST_REPORT) begin
                collision     <= acc_hit;
                hit_segment   <= acc_idx;
                any_collision <= |acc_hit;
            end
        end
    end

endmodule

// File: tb/tb_collision_scan_unit.sv
module tb_collision_scan_unit;

    localparam int NS = 7;
    localparam int NE = 3;
    localparam int PW = 8;
    localparam int SW = 3;

    localparam int NS2 = 1;
    localparam int NE2 = 5;
    localparam int PW2 = 10;
    localparam int SW2 = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic               frame_start;
    logic [NE*PW-1:0]   entity_pos;
    logic [NE-1:0]      entity_valid;
    logic [NS*PW-1:0]   segment_pos;
    logic [NS-1:0]      segment_active;
    logic               busy, done, any_collision, overrun;
    logic [NE-1:0]      collision;
    logic [NE*SW-1:0]   hit_segment;

    logic               b_frame_start;
    logic [NE2*PW2-1:0] b_entity_pos;
    logic [NE2-1:0]     b_entity_valid;
    logic [NS2*PW2-1:0] b_segment_pos;
    logic [NS2-1:0]     b_segment_active;
    logic               b_busy, b_done, b_any_collision, b_overrun;
    logic [NE2-1:0]     b_collision;
    logic [NE2*SW2-1:0] b_hit_segment;

    collision_scan_unit dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .entity_pos     (entity_pos),
        .entity_valid   (entity_valid),
        .segment_pos    (segment_pos),
        .segment_active (segment_active),
        .busy           (busy),
        .done           (done),
        .collision      (collision),
        .hit_segment    (hit_segment),
        .any_collision  (any_collision),
        .overrun        (overrun)
    );

    collision_scan_unit #(
        .NUM_SEGMENTS (NS2),
        .NUM_ENTITIES (NE2),
        .POS_WIDTH    (PW2)
    ) dut_b (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (b_frame_start),
        .entity_pos     (b_entity_pos),
        .entity_valid   (b_entity_valid),
        .segment_pos    (b_segment_pos),
        .segment_active (b_segment_active),
        .busy           (b_busy),
        .done           (b_done),
        .collision      (b_collision),
        .hit_segment    (b_hit_segment),
        .any_collision  (b_any_collision),
        .overrun        (b_overrun)
    );

    typedef struct {
        logic [NE*PW-1:0] ep;
        logic [NE-1:0]    ev;
        logic [NS*PW-1:0] sp;
        logic [NS-1:0]    sa;
        logic [NE-1:0]    ecol;
        logic [NE*SW-1:0] ehs;
        bit               scramble;
    } vec_t;

    vec_t tbl [5];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: for each entity, the first (lowest) active segment at the
    // same position, only if the entity is valid.
    function automatic void ref_model(input logic [NE*PW-1:0] ep, input logic [NE-1:0] ev,
                                      input logic [NS*PW-1:0] sp, input logic [NS-1:0] sa,
                                      output logic [NE-1:0] col, output logic [NE*SW-1:0] hs);
        col = '0;
        hs  = '0;
        for (int e = 0; e < NE; e++) begin
            for (int s = 0; s < NS; s++) begin
                if (!col[e] && ev[e] && sa[s] && ep[e*PW +: PW] == sp[s*PW +: PW]) begin
                    col[e]            = 1'b1;
                    hs[e*SW +: SW]    = SW'(s);
                end
            end
        end
    endfunction

    task automatic rand_inputs();
        for (int e = 0; e < NE; e++) entity_pos[e*PW +: PW] = PW'($urandom_range(0, 3));
        for (int s = 0; s < NS; s++) segment_pos[s*PW +: PW] = PW'($urandom_range(0, 3));
        entity_valid   = NE'($urandom);
        segment_active = NS'($urandom);
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Waits for done after the capture edge. A second request is raised so
    // that it is sampled at edge number inject_at (0 = none); busy and
    // overrun are checked on every cycle.
    task automatic wait_done(input int inject_at, output int lat);
        bit exp_ovr;
        lat = 0;
        while (1) begin
            if (inject_at != 0 && lat + 1 == inject_at) frame_start = 1'b1;
            @(posedge clk);
            #1;
            lat++;
            if (lat == inject_at) frame_start = 1'b0;
            exp_ovr = (inject_at >= 1) && (inject_at <= NS) && (lat == inject_at);
            check("overrun", 64'(overrun), 64'(exp_ovr));
            if (done || lat >= 20) break;
            check("busy_during_scan", 64'(busy), 64'd1);
        end
        check("latency", 64'(lat), 64'(NS + 1));
        check("busy_at_done", 64'(busy), 64'(inject_at == NS + 1));
    endtask

    task automatic check_results(input string tag, input logic [NE-1:0] ecol, input logic [NE*SW-1:0] ehs);
        check({tag, "_collision"}, 64'(collision), 64'(ecol));
        check({tag, "_hit_segment"}, 64'(hit_segment), 64'(ehs));
        check({tag, "_any"}, 64'(any_collision), 64'(|ecol));
    endtask

    initial begin
        logic [NS*PW-1:0] bg;
        logic [NE-1:0]    mcol;
        logic [NE*SW-1:0] mhs;
        bit               dflag;
        int               lat;

        reset          = 1'b1;
        frame_start    = 1'b0;
        entity_pos     = '0;
        entity_valid   = '0;
        segment_pos    = '0;
        segment_active = '0;
        b_frame_start    = 1'b0;
        b_entity_pos     = '0;
        b_entity_valid   = '0;
        b_segment_pos    = '0;
        b_segment_active = '0;

        for (int s = 0; s < NS; s++) bg[s*PW +: PW] = PW'(8'hA0 + s);

        // player defaults 0x23, sword 0x44, sheep 0x55
        tbl[0].ep = {8'h55, 8'h44, 8'h23}; tbl[0].ev = 3'b111; tbl[0].sp = bg;
        tbl[0].sp[4*PW +: PW] = 8'h23; tbl[0].sa = 7'h7F;
        tbl[0].ecol = 3'b001; tbl[0].ehs = {3'd0, 3'd0, 3'd4}; tbl[0].scramble = 1'b0;

        tbl[1].ep = {8'h55, 8'h44, 8'h11}; tbl[1].ev = 3'b111; tbl[1].sp = bg;
        tbl[1].sp[2*PW +: PW] = 8'h11; tbl[1].sp[5*PW +: PW] = 8'h11; tbl[1].sa = 7'h7F;
        tbl[1].ecol = 3'b001; tbl[1].ehs = {3'd0, 3'd0, 3'd2}; tbl[1].scramble = 1'b0;

        tbl[2] = tbl[1]; tbl[2].sa = 7'b1111011; tbl[2].ehs = {3'd0, 3'd0, 3'd5};

        tbl[3].ep = {8'h55, 8'h44, 8'h23}; tbl[3].ev = 3'b011; tbl[3].sp = bg;
        tbl[3].sp[3*PW +: PW] = 8'h44; tbl[3].sp[0*PW +: PW] = 8'h55; tbl[3].sa = 7'b1110111;
        tbl[3].ecol = 3'b000; tbl[3].ehs = '0; tbl[3].scramble = 1'b0;

        tbl[4].ep = {8'h55, 8'h44, 8'h23}; tbl[4].ev = 3'b111; tbl[4].sp = bg;
        tbl[4].sp[0*PW +: PW] = 8'h55; tbl[4].sp[1*PW +: PW] = 8'h44;
        tbl[4].sp[6*PW +: PW] = 8'h23; tbl[4].sa = 7'h7F;
        tbl[4].ecol = 3'b111; tbl[4].ehs = {3'd0, 3'd1, 3'd6}; tbl[4].scramble = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_collision", 64'(collision), 64'd0);
        check("rst_hit_segment", 64'(hit_segment), 64'd0);
        check("rst_any", 64'(any_collision), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // table vectors
        for (int i = 0; i < 5; i++) begin
            entity_pos = tbl[i].ep; entity_valid = tbl[i].ev;
            segment_pos = tbl[i].sp; segment_active = tbl[i].sa;
            start_frame();
            if (tbl[i].scramble) begin
                entity_pos     = ~entity_pos;
                segment_pos    = ~segment_pos;
                entity_valid   = '0;
                segment_active = '0;
            end
            wait_done(0, lat);
            check_results($sformatf("vec%0d", i), tbl[i].ecol, tbl[i].ehs);
            @(posedge clk); #1;
            check("done_pulse", 64'(done), 64'd0);
            check("results_hold", 64'(collision), 64'(tbl[i].ecol));
        end

        // overrun at SCAN cycle 3, done timing unchanged
        entity_pos = tbl[0].ep; entity_valid = tbl[0].ev;
        segment_pos = tbl[0].sp; segment_active = tbl[0].sa;
        start_frame();
        wait_done(3, lat);
        check_results("overrun_frame", tbl[0].ecol, tbl[0].ehs);

        // back-to-back: second request in the REPORT cycle
        @(posedge clk); #1;
        entity_pos = tbl[4].ep; entity_valid = tbl[4].ev;
        segment_pos = tbl[4].sp; segment_active = tbl[4].sa;
        start_frame();
        entity_pos = tbl[1].ep; entity_valid = tbl[1].ev;
        segment_pos = tbl[1].sp; segment_active = tbl[1].sa;
        wait_done(NS + 1, lat);
        check_results("b2b_first", tbl[4].ecol, tbl[4].ehs);
        wait_done(0, lat);
        check_results("b2b_second", tbl[1].ecol, tbl[1].ehs);

        // reset mid-scan
        @(posedge clk); #1;
        entity_pos = tbl[0].ep; entity_valid = tbl[0].ev;
        segment_pos = tbl[0].sp; segment_active = tbl[0].sa;
        start_frame();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_collision", 64'(collision), 64'd0);
        check("midrst_hit_segment", 64'(hit_segment), 64'd0);
        check("midrst_any", 64'(any_collision), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dflag = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) dflag = 1'b1;
        end
        check("midrst_no_done", 64'(dflag), 64'd0);

        // randomized frames against the reference model
        for (int i = 0; i < 30; i++) begin
            rand_inputs();
            ref_model(entity_pos, entity_valid, segment_pos, segment_active, mcol, mhs);
            start_frame();
            if (i % 2 == 1) rand_inputs();
            wait_done(0, lat);
            check_results($sformatf("rand%0d", i), mcol, mhs);
        end

        // single-segment, five-entity, 10-bit configuration
        b_entity_pos     = {10'h000, 10'h123, 10'h200, 10'h123, 10'h123};
        b_entity_valid   = 5'b11101;
        b_segment_pos    = 10'h123;
        b_segment_active = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            b_frame_start = 1'b1;
            @(posedge clk); #1;
            b_frame_start = 1'b0;
            check("cfg2_busy", 64'(b_busy), 64'd1);
            lat = 0;
            while (1) begin
                @(posedge clk); #1;
                lat++;
                if (b_done || lat >= 10) break;
            end
            check("cfg2_latency", 64'(lat), 64'd2);
            check("cfg2_collision", 64'(b_collision), (pass == 0) ? 64'h09 : 64'h00);
            check("cfg2_hit_segment", 64'(b_hit_segment), 64'd0);
            check("cfg2_any", 64'(b_any_collision), (pass == 0) ? 64'd1 : 64'd0);
            check("cfg2_busy_done", 64'(b_busy), 64'd0);
            b_segment_active = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_scan_unit.md
# collision_scan_unit

Parametrised frame-based collision detector between a configurable set of game entities (player, sword, sheep, …) and a configurable chain of dragon segments. Once per frame it snapshots all positions, scans one segment per cycle against every entity in parallel, and publishes registered per-entity collision flags plus the lowest-index segment hit, with a `done` pulse. It sits between the entity/dragon position logic and the game-state update logic, replacing the fixed 3-entity / 7-segment free-running checker.

## Interface

Parameters:
- `NUM_SEGMENTS`, 7, number of dragon segments scanned (≥1)
- `NUM_ENTITIES`, 3, number of entities checked in parallel (≥1)
- `POS_WIDTH`, 8, width of one packed position ({row, col})
- `SEG_IDX_W`, derived `max(1, clog2(NUM_SEGMENTS))`, segment index width

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `frame_start`  in  1  one-cycle request to start a scan
- `entity_pos`  in  NUM_ENTITIES*POS_WIDTH  entity e at bits [e*POS_WIDTH +: POS_WIDTH]
- `entity_valid`  in  NUM_ENTITIES  entity participates when 1
- `segment_pos`  in  NUM_SEGMENTS*POS_WIDTH  segment s at bits [s*POS_WIDTH +: POS_WIDTH]
- `segment_active`  in  NUM_SEGMENTS  segment participates when 1
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse: results updated
- `collision`  out  NUM_ENTITIES  entity e hit any active segment this frame
- `hit_segment`  out  NUM_ENTITIES*SEG_IDX_W  lowest segment index hit by entity e; 0 if none
- `any_collision`  out  1  OR of `collision`
- `overrun`  out  1  one-cycle pulse: `frame_start` dropped while scanning

## Operation

- States: IDLE, SCAN, REPORT.
- IDLE: on `frame_start`=1, capture `entity_pos`, `entity_valid`, `segment_pos`, `segment_active` into snapshot registers; clear accumulators; seg_idx←0; go to SCAN.
- SCAN: each cycle compare snapshot segment[seg_idx] against all entities. Entity e hits when entity_valid[e] & segment_active[seg_idx] & positions equal. On first hit for e, acc_hit[e]←1 and acc_idx[e]←seg_idx; later hits do not change acc_idx. seg_idx increments; after seg_idx = NUM_SEGMENTS−1 go to REPORT. Inactive segments still consume a cycle (fixed latency).
- REPORT: `collision`←acc_hit, `hit_segment`←acc_idx (0 where acc_hit=0), `any_collision`←|acc_hit, `done`=1. If `frame_start`=1 in this cycle, take snapshot and go to SCAN (back-to-back); else go to IDLE.
- `frame_start` during SCAN: ignored, `overrun` pulses next cycle; scan continues unaffected.
- Inputs change freely after capture; outputs hold last reported values until the next REPORT.
- Reset mid-scan: abort immediately, no `done`; all state and outputs cleared.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `collision`=0, `hit_segment`=0, `any_collision`=0, `overrun`=0, seg_idx=0.
- `frame_start` sampled at edge E0 → `busy`=1 from E0; comparisons at E1..E(NUM_SEGMENTS); results and `done`=1 valid after E(NUM_SEGMENTS+1), `busy`=0 in that same cycle unless back-to-back.
- Latency: NUM_SEGMENTS+1 cycles request-to-`done`; max throughput one scan per NUM_SEGMENTS+1 cycles.
- All outputs registered; no combinational input-to-output path.
- seg_idx never wraps past NUM_SEGMENTS−1; NUM_SEGMENTS=1 gives a single SCAN cycle.

## Structure

- Shared package `collision_pkg`: state encoding (IDLE/SCAN/REPORT), `clog2` helper for SEG_IDX_W, default parameter constants.
- Sub-module `position_comparator` (POS_WIDTH equality gated by enable), instantiated NUM_ENTITIES times in a generate loop; top handles FSM, snapshot, segment mux, accumulators.

## Test plan

- Defaults, player=0x23, segment 4=0x23 active, others differ; `frame_start` → `done` exactly 8 cycles later, collision=3'b001, hit_segment[0]=4, any_collision=1.
- Player 0x11 matches segments 2 and 5, both active → hit_segment[0]=2; deactivate segment 2 next frame → hit_segment[0]=5.
- Sword matches inactive segment 3 and sheep invalid but matching segment 0 → collision=0, any_collision=0, `done` still pulses.
- `frame_start` at SCAN cycle 3 → `overrun` one-cycle pulse, `done` timing unchanged; `frame_start` in REPORT cycle → new scan, `busy` stays 1, second `done` 8 cycles later.
- Change `entity_pos` mid-scan → results reflect captured snapshot only.
- Assert `reset` at SCAN cycle 4 → all outputs 0 immediately, no `done`; NUM_SEGMENTS=1, NUM_ENTITIES=5, POS_WIDTH=10 config → `done` 2 cycles after request with correct flags.
